// File: rtl/dbus_uart_pkg.sv
// Shared constants for the data-bus UART transmitter:
// register offsets, status bit positions, FSM encoding.
package dbus_uart_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small circular transmit FIFO. A pop and a push on the
// same edge are both honoured even when full.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;
    logic             do_push;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers, count and storage.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO state registers; reset discards all contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dbus_uart_tx.sv
// Data-bus mapped 8N1 UART transmitter: address decode,
// registers, transmit FIFO and serializer FSM.
module dbus_uart_tx
    import dbus_uart_pkg::*;
#(
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        DATA_BUS_WIDTH = 17,
    parameter logic [DATA_BUS_WIDTH-1:0] BASE_ADDR      = 17'h1FF00,
    parameter int                        FIFO_DEPTH     = 4,
    parameter int                        DEFAULT_DIV    = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmemread,
    input  logic                      dmemwrite,
    input  logic [DATA_BUS_WIDTH-1:0] dadr,
    input  logic [DATA_WIDTH-1:0]     dmemwd,
    output logic                      sel,
    output logic [DATA_WIDTH-1:0]     dmemrd,
    output logic                      txd,
    output logic                      busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       off;
    logic             push_req;
    logic             wr_div;
    logic             rd_stat;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic [7:0]       status;
    logic             tx_active;
    logic             unused_bits;

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] fdiv_q, fdiv_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             ovr_q, ovr_d;

    assign unused_bits = ^{dadr[1:0], dmemwd[DATA_WIDTH-1:DIV_W]};

    assign sel = (dadr[DATA_BUS_WIDTH-1:4] == BASE_ADDR[DATA_BUS_WIDTH-1:4]);
    assign off = dadr[3:2];

    assign push_req  = sel && dmemwrite && (off == OFF_TXDATA);
    assign wr_div    = sel && dmemwrite && (off == OFF_DIVISOR);
    assign rd_stat   = sel && dmemread && (off == OFF_STATUS);
    assign tx_active = (state_q != TX_IDLE);
    assign busy      = !fifo_empty || tx_active;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (dmemwd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Assemble the status byte.
    always_comb begin
        status = '0;
        status[ST_EMPTY]   = fifo_empty;
        status[ST_FULL]    = fifo_full;
        status[ST_ACTIVE]  = tx_active;
        status[ST_OVERRUN] = ovr_q;
        status[ST_COUNT_LSB +: 4] = 4'(fifo_count);
    end

    // Zero-latency read mux; unmapped or idle reads return 0.
    always_comb begin
        dmemrd = '0;
        if (sel && dmemread) begin
            case (off)
                OFF_STATUS:  dmemrd[7:0] = status;
                OFF_DIVISOR: dmemrd[DIV_W-1:0] = div_q;
                default:     dmemrd = '0;
            endcase
        end
    end

    // Divisor and sticky overrun updates; an overrun set beats a clear.
    always_comb begin
        div_d = div_q;
        ovr_d = ovr_q;
        if (wr_div) begin
            if (dmemwd[DIV_W-1:0] == '0) begin
                div_d = DIV_W'(1);
            end else begin
                div_d = dmemwd[DIV_W-1:0];
            end
        end
        if (rd_stat) begin
            ovr_d = 1'b0;
        end
        if (push_req && fifo_full && !fifo_pop) begin
            ovr_d = 1'b1;
        end
    end

    // Transmitter next state: bit timing, shifting and FIFO pops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fdiv_d   = fdiv_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    fdiv_d   = div_q;
                    cnt_d    = div_q - DIV_W'(1);
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    idx_d   = 3'd0;
                    cnt_d   = fdiv_q - DIV_W'(1);
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = fdiv_q - DIV_W'(1);
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        fdiv_d   = div_q;
                        cnt_d    = div_q - DIV_W'(1);
                        state_d  = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Line level follows the current bit; idle and stop are high.
    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = shift_q[0];
            default:  txd = 1'b1;
        endcase
    end

    // State registers for the FSM and the bus-visible registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            fdiv_q  <= DIV_W'(DEFAULT_DIV);
            div_q   <= DIV_W'(DEFAULT_DIV);
            idx_q   <= '0;
            shift_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fdiv_q  <= fdiv_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx: reset, single frame,
// back-to-back frames, overrun, decode, reset mid-frame.
module tb_dbus_uart_tx;

    localparam logic [16:0] BASE    = 17'h1FF00;
    localparam logic [16:0] A_TX    = BASE + 17'h0;
    localparam logic [16:0] A_STAT  = BASE + 17'h4;
    localparam logic [16:0] A_DIV   = BASE + 17'h8;
    localparam logic [16:0] A_RSVD  = BASE + 17'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dmemread = 1'b0;
    logic        dmemwrite = 1'b0;
    logic [16:0] dadr = '0;
    logic [31:0] dmemwd = '0;
    logic        sel;
    logic [31:0] dmemrd;
    logic        txd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dbus_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .dmemread  (dmemread),
        .dmemwrite (dmemwrite),
        .dadr      (dadr),
        .dmemwd    (dmemwd),
        .sel       (sel),
        .dmemrd    (dmemrd),
        .txd       (txd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [16:0] a, input logic [31:0] d);
        @(negedge clk);
        dmemwrite = 1'b1;
        dadr = a;
        dmemwd = d;
        @(negedge clk);
        dmemwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [16:0] a, output logic [31:0] v,
                            output logic s);
        @(negedge clk);
        dmemread = 1'b1;
        dadr = a;
        #1;
        v = dmemrd;
        s = sel;
        @(negedge clk);
        dmemread = 1'b0;
    endtask

    // Expected line level for sample i of a train of 10*div-cycle frames.
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        logic [7:0] t;
        t = b;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return t[pos-1];
    endfunction

    task automatic test_reset;
        logic [31:0] v;
        logic s;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: got %b want 1", txd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        bus_read(A_STAT, v, s);
        checks++;
        if (v !== 32'h01 || s !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %h sel %b want 00000001 sel 1", v, s);
        end
        bus_read(A_DIV, v, s);
        checks++;
        if (v !== 32'd868) begin
            errors++;
            $display("FAIL reset_divisor: got %0d want 868", v);
        end
    endtask

    task automatic test_single_frame;
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h55);
        checks++;
        if (busy !== 1'b1 || txd !== 1'b1) begin
            errors++;
            $display("FAIL single_after_write: busy %b txd %b want 1 1", busy, txd);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== frame_bit(8'h55, i / 4)) begin
                errors++;
                $display("FAIL single_txd[%0d]: got %b want %b", i, txd,
                         frame_bit(8'h55, i / 4));
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL single_end: busy %b txd %b want 0 1", busy, txd);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        logic exp;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        bytes[2] = 8'hFF;
        bus_write(A_DIV, 32'd2);
        dmemwrite = 1'b1;
        dadr = A_TX;
        dmemwd = 32'hA5;
        @(negedge clk);
        dmemwd = 32'h3C;
        @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_txd[0]: got %b want 0", txd);
        end
        dmemwd = 32'hFF;
        @(negedge clk);
        dmemwrite = 1'b0;
        dmemread = 1'b1;
        dadr = A_STAT;
        #1;
        checks++;
        if (dmemrd[7:4] !== 4'd2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", dmemrd[7:4]);
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_txd[1]: got %b want 0", txd);
        end
        @(negedge clk);
        dmemread = 1'b0;
        for (int i = 2; i < 60; i++) begin
            if (i > 2) @(negedge clk);
            exp = frame_bit(bytes[i / 20], (i % 20) / 2);
            checks++;
            if (txd !== exp) begin
                errors++;
                $display("FAIL b2b_txd[%0d]: got %b want %b", i, txd, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_overrun;
        bus_write(A_DIV, 32'd100);
        dmemwrite = 1'b1;
        dadr = A_TX;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            dmemwd = 32'h10 + 32'(i);
        end
        @(negedge clk);
        dmemwrite = 1'b0;
        dmemread = 1'b1;
        dadr = A_STAT;
        #1;
        checks++;
        if (dmemrd !== 32'h4E) begin
            errors++;
            $display("FAIL overrun_status: got %h want 0000004e", dmemrd);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dmemrd !== 32'h46) begin
            errors++;
            $display("FAIL overrun_clear: got %h want 00000046", dmemrd);
        end
        dmemread = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_decode;
        logic [31:0] v;
        logic s;
        bus_write(A_RSVD, 32'hFF);
        bus_read(A_RSVD, v, s);
        checks++;
        if (v !== 32'h0 || s !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_read: got %h sel %b want 0 sel 1", v, s);
        end
        bus_read(A_TX, v, s);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: got %h want 0", v);
        end
        bus_read(BASE - 17'd4, v, s);
        checks++;
        if (v !== 32'h0 || s !== 1'b0) begin
            errors++;
            $display("FAIL below_base: got %h sel %b want 0 sel 0", v, s);
        end
        bus_read(BASE + 17'd16, v, s);
        checks++;
        if (v !== 32'h0 || s !== 1'b0) begin
            errors++;
            $display("FAIL above_top: got %h sel %b want 0 sel 0", v, s);
        end
        bus_write(A_DIV, 32'h0);
        bus_read(A_DIV, v, s);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL div_zero: got %0d want 1", v);
        end
        bus_read(A_STAT, v, s);
        checks++;
        if (v !== 32'h01) begin
            errors++;
            $display("FAIL decode_status: got %h want 00000001", v);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] v;
        logic s;
        bus_write(A_DIV, 32'd4);
        dmemwrite = 1'b1;
        dadr = A_TX;
        dmemwd = 32'h00;
        @(negedge clk);
        dmemwd = 32'hF0;
        @(negedge clk);
        dmemwrite = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit3: got %b want 0", txd);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: txd %b busy %b want 1 0", txd, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_STAT, v, s);
        checks++;
        if (v !== 32'h01) begin
            errors++;
            $display("FAIL mid_status: got %h want 00000001", v);
        end
        bus_read(A_DIV, v, s);
        checks++;
        if (v !== 32'd868) begin
            errors++;
            $display("FAIL mid_divisor: got %0d want 868", v);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1) begin
                errors++;
                $display("FAIL mid_quiet[%0d]: got %b want 1", i, txd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_decode();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
